// File: rtl/micro_sequencer.sv
// Loadable microprogram sequencer: writable control store, start/done handshake,
// conditional branching on cres and a step limit that bounds every run.
module micro_sequencer #(
  parameter int P_LOG_MEMSIZE    = 4,
  parameter int P_NUM_D_CTRLBITS = 5,
  parameter int P_NUM_C_CTRLBITS = 2,
  parameter int P_STEP_W         = 8
) (
  input  logic                                                      clk,
  input  logic                                                      rst,
  input  logic                                                      prog_we,
  input  logic [P_LOG_MEMSIZE-1:0]                                  prog_addr,
  input  logic [P_NUM_C_CTRLBITS+P_LOG_MEMSIZE+P_NUM_D_CTRLBITS-1:0] prog_data,
  input  logic                                                      start,
  input  logic                                                      abort,
  input  logic                                                      cres,
  output logic [P_NUM_D_CTRLBITS-1:0]                               dp_ctrl,
  output logic                                                      busy,
  output logic                                                      done,
  output logic                                                      err,
  output logic [P_LOG_MEMSIZE-1:0]                                  pc
);

  localparam int W     = P_NUM_C_CTRLBITS + P_LOG_MEMSIZE + P_NUM_D_CTRLBITS;
  localparam int DEPTH = 2 ** P_LOG_MEMSIZE;

  localparam logic [P_NUM_C_CTRLBITS-1:0] COND_ADV = P_NUM_C_CTRLBITS'(0);
  localparam logic [P_NUM_C_CTRLBITS-1:0] COND_JMP = P_NUM_C_CTRLBITS'(1);
  localparam logic [P_NUM_C_CTRLBITS-1:0] COND_BRC = P_NUM_C_CTRLBITS'(2);
  localparam logic [P_NUM_C_CTRLBITS-1:0] COND_HLT = P_NUM_C_CTRLBITS'(3);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      state;
  logic [P_STEP_W-1:0]         step;
  logic [W-1:0]                mem [DEPTH];
  logic [W-1:0]                word;
  logic [P_NUM_C_CTRLBITS-1:0] cond;
  logic [P_LOG_MEMSIZE-1:0]    target;
  logic [P_NUM_D_CTRLBITS-1:0] dctl;
  logic [P_LOG_MEMSIZE-1:0]    pc_inc;

  assign word   = mem[pc];
  assign cond   = word[W-1 -: P_NUM_C_CTRLBITS];
  assign target = word[P_NUM_D_CTRLBITS +: P_LOG_MEMSIZE];
  assign dctl   = word[P_NUM_D_CTRLBITS-1:0];
  assign pc_inc = pc + P_LOG_MEMSIZE'(1);

  // Control store has no reset so a program survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && prog_we)
      mem[prog_addr] <= prog_data;
  end

  always_comb begin
    dp_ctrl = '0;
    if (state == RUN && !abort && cond != COND_HLT)
      dp_ctrl = dctl;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pc    <= '0;
      step  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            pc    <= '0;
            step  <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          step <= step + P_STEP_W'(1);
          // Ending conditions in priority order: abort, halt word, step limit.
          if (abort) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (cond == COND_HLT) begin
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            case (cond)
              COND_JMP: pc <= target;
              COND_BRC: pc <= cres ? target : pc_inc;
              default:  pc <= pc_inc;
            endcase
            if (step == '1) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
